uart_fifo_bridge: RTL

- Buffering stage between the host/bus side and the UART transceiver.
- TX side: queues host bytes and issues them to the transceiver one at a time. It pulses the transceiver's tx write strobe, then waits for its tx_done pulse before sending the next byte.
- RX side: captures each rx_done/rx_data pulse from the transceiver into a FIFO, which the host drains.
- Sticky overflow, overrun and break flags are reported to the host.

---
 rtl/uart_fifo_bridge_if.sv | 44 ++++
 rtl/uart_fifo_bridge.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge_if.sv
// Host-side and transceiver-side signal bundle for uart_fifo_bridge.
// The bridge connects through the slave modport. Whatever drives the host
// and transceiver pins, such as a bus adapter or a testbench, uses the
// master modport.
interface uart_fifo_bridge_if #(
    parameter int DEPTH_LOG2 = 4
);
    // Host side
    logic                  tx_push;
    logic [7:0]            tx_push_data;
    logic                  tx_full;
    logic [DEPTH_LOG2:0]   tx_level;
    logic                  tx_idle;
    logic                  rx_pop;
    logic [7:0]            rx_pop_data;
    logic                  rx_empty;
    logic [DEPTH_LOG2:0]   rx_level;
    logic                  clr_flags;
    logic                  tx_overflow;
    logic                  rx_overrun;
    logic                  rx_break_seen;

    // Transceiver side
    logic [7:0]            xcvr_tx_data;
    logic                  xcvr_tx_wr;
    logic                  xcvr_tx_done;
    logic [7:0]            xcvr_rx_data;
    logic                  xcvr_rx_done;
    logic                  xcvr_rx_break;

    modport slave (
        input  tx_push, tx_push_data, rx_pop, clr_flags,
               xcvr_tx_done, xcvr_rx_data, xcvr_rx_done, xcvr_rx_break,
        output tx_full, tx_level, tx_idle, rx_pop_data, rx_empty, rx_level,
               tx_overflow, rx_overrun, rx_break_seen, xcvr_tx_data, xcvr_tx_wr
    );

    modport master (
        output tx_push, tx_push_data, rx_pop, clr_flags,
               xcvr_tx_done, xcvr_rx_data, xcvr_rx_done, xcvr_rx_break,
        input  tx_full, tx_level, tx_idle, rx_pop_data, rx_empty, rx_level,
               tx_overflow, rx_overrun, rx_break_seen, xcvr_tx_data, xcvr_tx_wr
    );
endinterface

// File: rtl/uart_fifo_bridge.sv
// Buffering stage between a host and a UART transceiver.
// The TX FIFO feeds the transceiver one byte at a time, and a new byte is
// issued only after the previous tx_done. The RX FIFO captures received
// bytes for the host. Sticky overflow, overrun and break flags are reported
// to the host.
module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    uart_fifo_bridge_if.slave  bus
);
    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] ONE        = (DEPTH_LOG2+1)'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [7:0]            r_tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_tx_wr_ptr, r_tx_rd_ptr;
    logic [DEPTH_LOG2:0]   r_tx_count;
    logic [7:0]            r_rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rx_wr_ptr, r_rx_rd_ptr;
    logic [DEPTH_LOG2:0]   r_rx_count;
    logic [0:0]            r_state;
    logic [7:0]            r_xcvr_tx_data;
    logic                  r_xcvr_tx_wr;
    logic                  r_tx_overflow, r_rx_overrun, r_rx_break_seen;

    logic w_tx_full, w_tx_wr_en, w_tx_rd_en;
    logic w_rx_full, w_rx_wr_en, w_rx_rd_en;

    // Full is evaluated from the registered count. A write into a full FIFO
    // is dropped even when a pop happens in the same cycle.
    assign w_tx_full  = (r_tx_count == FULL_COUNT);
    assign w_tx_wr_en = bus.tx_push && !w_tx_full;
    assign w_tx_rd_en = (r_state == ST_IDLE) && (r_tx_count != '0);
    assign w_rx_full  = (r_rx_count == FULL_COUNT);
    assign w_rx_wr_en = bus.xcvr_rx_done && !w_rx_full;
    assign w_rx_rd_en = bus.rx_pop && (r_rx_count != '0);

    assign bus.tx_full       = w_tx_full;
    assign bus.tx_level      = r_tx_count;
    assign bus.tx_idle       = (r_state == ST_IDLE) && (r_tx_count == '0);
    assign bus.rx_empty      = (r_rx_count == '0);
    assign bus.rx_level      = r_rx_count;
    assign bus.rx_pop_data   = r_rx_mem[r_rx_rd_ptr];
    assign bus.xcvr_tx_data  = r_xcvr_tx_data;
    assign bus.xcvr_tx_wr    = r_xcvr_tx_wr;
    assign bus.tx_overflow   = r_tx_overflow;
    assign bus.rx_overrun    = r_rx_overrun;
    assign bus.rx_break_seen = r_rx_break_seen;

    // TX storage write. Entries are only meaningful between the pointers.
    // NOTE: memory arrays are left unreset; resetting the pointers is enough and keeps the array RAM-inferable.
    always_ff @(posedge sys_clk) begin
        if (w_tx_wr_en) r_tx_mem[r_tx_wr_ptr] <= bus.tx_push_data;
    end

    // TX pointers and occupancy; a simultaneous write and pop keeps the count.
    always_ff @(posedge sys_clk) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (sys_rst) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= '0;
        end else begin
            if (w_tx_wr_en) r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
            if (w_tx_rd_en) r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
            case ({w_tx_wr_en, w_tx_rd_en})
                2'b10:   r_tx_count <= r_tx_count + ONE;
                2'b01:   r_tx_count <= r_tx_count - ONE;
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // TX FSM: issue the head byte with a one-cycle strobe, then wait for tx_done.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state        <= ST_IDLE;
            r_xcvr_tx_wr   <= 1'b0;
            r_xcvr_tx_data <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_xcvr_tx_wr <= 1'b0;
                    if (w_tx_rd_en) begin
                        r_xcvr_tx_data <= r_tx_mem[r_tx_rd_ptr];
                        r_xcvr_tx_wr   <= 1'b1;
                        r_state        <= ST_WAIT;
                    end
                end
                default: begin
                    r_xcvr_tx_wr <= 1'b0;
                    if (bus.xcvr_tx_done) r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // RX storage write from the transceiver receive pulse.
    always_ff @(posedge sys_clk) begin
        if (w_rx_wr_en) r_rx_mem[r_rx_wr_ptr] <= bus.xcvr_rx_data;
    end

    // RX pointers and occupancy; a pop on an empty FIFO is ignored.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= '0;
        end else begin
            if (w_rx_wr_en) r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
            if (w_rx_rd_en) r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
            case ({w_rx_wr_en, w_rx_rd_en})
                2'b10:   r_rx_count <= r_rx_count + ONE;
                2'b01:   r_rx_count <= r_rx_count - ONE;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // Sticky flags: a set event wins over clr_flags in the same cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_tx_overflow   <= 1'b0;
            r_rx_overrun    <= 1'b0;
            r_rx_break_seen <= 1'b0;
        end else begin
            if (bus.tx_push && w_tx_full)           r_tx_overflow   <= 1'b1;
            else if (bus.clr_flags)                 r_tx_overflow   <= 1'b0;
            if (bus.xcvr_rx_done && w_rx_full)      r_rx_overrun    <= 1'b1;
            else if (bus.clr_flags)                 r_rx_overrun    <= 1'b0;
            if (bus.xcvr_rx_break)                  r_rx_break_seen <= 1'b1;
            else if (bus.clr_flags)                 r_rx_break_seen <= 1'b0;
        end
    end
endmodule
